// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 hex keypad one column at a time. It synchronises and debounces
// the row lines and accepts exactly one digit per physical key press. The two
// most recent digits are kept as a shift pair for a two-digit display.
//
// Ports
//   clk        : system clock, all logic on posedge
//   reset      : synchronous, active-high
//   rows[3:0]  : raw keypad rows, asynchronous, active-low (pulled up)
//   cols[3:0]  : column drive, active-low, exactly one bit low
//   digit_old  : previous accepted digit (left display)
//   digit_new  : most recent accepted digit (right display)
//   key_valid  : one-cycle strobe on the cycle the digit pair updates
//   state_dbg  : current FSM state (0 SCAN, 1 DEBOUNCE, 2 HELD, 3 RELEASE)
//
// Handshake: key_valid is a valid-only strobe with no ready. The consumer
// must take digit_old/digit_new on the cycle key_valid is high. Both digits
// then hold their values until the next strobe.
// ---------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_COUNT     = 50_000,
    parameter int DEBOUNCE_COUNT = 240_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] digit_old,
    output logic [3:0] digit_new,
    output logic       key_valid,
    output logic [1:0] state_dbg
);

    localparam int MAX_COUNT = (SCAN_COUNT > DEBOUNCE_COUNT) ? SCAN_COUNT : DEBOUNCE_COUNT;
    localparam int CW        = $clog2(MAX_COUNT + 1);

    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_COUNT - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_COUNT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t        state;
    logic [3:0]    sync1;
    logic [3:0]    rs;
    logic [CW-1:0] cnt;
    logic [1:0]    col_idx;
    logic [3:0]    cap_rows;
    logic [1:0]    cap_col;

    // True when exactly one row line is pulled low.
    function automatic logic single_low(input logic [3:0] v);
        return ($countones(~v) == 1);
    endfunction

    // Row index of the single low bit in a captured pattern.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        case (v)
            4'b1110: return 2'd0;
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'd0:    return 4'h1;
            4'd1:    return 4'h2;
            4'd2:    return 4'h3;
            4'd3:    return 4'hA;
            4'd4:    return 4'h4;
            4'd5:    return 4'h5;
            4'd6:    return 4'h6;
            4'd7:    return 4'hB;
            4'd8:    return 4'h7;
            4'd9:    return 4'h8;
            4'd10:   return 4'h9;
            4'd11:   return 4'hC;
            4'd12:   return 4'hE;
            4'd13:   return 4'h0;
            4'd14:   return 4'hF;
            default: return 4'hD;
        endcase
    endfunction

    // Column decode from a register only, so there is no path from rows.
    assign cols      = ~(4'b0001 << col_idx);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= 4'hF;
            rs        <= 4'hF;
            state     <= ST_SCAN;
            cnt       <= '0;
            col_idx   <= 2'd0;
            cap_rows  <= 4'hF;
            cap_col   <= 2'd0;
            digit_old <= 4'h0;
            digit_new <= 4'h0;
            key_valid <= 1'b0;
        end else begin
            sync1     <= rows;
            rs        <= sync1;
            key_valid <= 1'b0;

            case (state)
                ST_SCAN: begin
                    if (cnt == SCAN_LAST) begin
                        cnt <= '0;
                        // Multiple rows low is ambiguous, so it is treated like no key.
                        if (single_low(rs)) begin
                            cap_rows <= rs;
                            cap_col  <= col_idx;
                            state    <= ST_DEBOUNCE;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                ST_DEBOUNCE: begin
                    // A mismatch wins even on the last count: acceptance
                    // requires the full run of matching cycles.
                    if (rs != cap_rows) begin
                        cnt     <= '0;
                        col_idx <= col_idx + 2'd1;
                        state   <= ST_SCAN;
                    end else if (cnt == DEB_LAST) begin
                        cnt       <= '0;
                        digit_old <= digit_new;
                        digit_new <= key_map(low_index(cap_rows), cap_col);
                        key_valid <= 1'b1;
                        state     <= ST_HELD;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                ST_HELD: begin
                    // Any other key, even in the same column, is ignored here.
                    if (rs == 4'b1111) begin
                        cnt   <= '0;
                        state <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    if (rs != 4'b1111) begin
                        cnt   <= '0;
                        state <= ST_HELD;
                    end else if (cnt == DEB_LAST) begin
                        cnt     <= '0;
                        col_idx <= col_idx + 2'd1;
                        state   <= ST_SCAN;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: begin
                    cnt   <= '0;
                    state <= ST_SCAN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

    localparam int SCAN_COUNT     = 4;
    localparam int DEBOUNCE_COUNT = 8;

    localparam logic [1:0] S_SCAN     = 2'd0;
    localparam logic [1:0] S_DEBOUNCE = 2'd1;
    localparam logic [1:0] S_HELD     = 2'd2;
    localparam logic [1:0] S_RELEASE  = 2'd3;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] digit_old;
    logic [3:0] digit_new;
    logic       key_valid;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_COUNT    (SCAN_COUNT),
        .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rows     (rows),
        .cols     (cols),
        .digit_old(digit_old),
        .digit_new(digit_new),
        .key_valid(key_valid),
        .state_dbg(state_dbg)
    );

    // ---------------- keypad model ----------------
    // pressed[r*4+c] closes the switch between row r and column c.
    logic [15:0] pressed = 16'h0;
    logic [3:0]  rows_m;

    always_comb begin
        rows_m = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !cols[c]) rows_m[r] = 1'b0;
    end
    assign rows = rows_m;

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [3:0] exp_old = 4'h0;
    logic [3:0] exp_new = 4'h0;
    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            logic [7:0] e;
            pulse_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: got old=%h new=%h, required no pulse", digit_old, digit_new);
            end else begin
                e = exp_q.pop_front();
                if ({digit_old, digit_new} !== e) begin
                    n_fail++;
                    $display("FAIL pulse_digits: got %h%h, required %h", digit_old, digit_new, e);
                end
            end
        end
    end

    task automatic expect_digit(input logic [3:0] d);
        exp_q.push_back({exp_new, d});
        exp_old = exp_new;
        exp_new = d;
    endtask

    // ---------------- driver / wait tasks ----------------
    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (state_dbg == s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_pulse(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic press_release(input int idx, input logic [3:0] d, output bit ok);
        bit ok1, ok2;
        expect_digit(d);
        drive_edge();
        pressed[idx] = 1'b1;
        wait_pulse(200, ok1);
        repeat (5) drive_edge();
        pressed[idx] = 1'b0;
        wait_state(S_SCAN, 40, ok2);
        ok = ok1 && ok2;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [3:0] ec;
        reset = 1'b1;
        pressed = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (cols !== 4'b1110 || digit_old !== 4'h0 || digit_new !== 4'h0 ||
            key_valid !== 1'b0 || state_dbg !== S_SCAN) begin
            n_fail++;
            $display("FAIL reset_values: got cols=%b old=%h new=%h kv=%b st=%0d, required 1110 0 0 0 0",
                     cols, digit_old, digit_new, key_valid, state_dbg);
        end
        drive_edge();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ec = ~(4'b0001 << ((i / 4) % 4));
            n_checks++;
            if (cols !== ec || key_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_scan[%0d]: got cols=%b kv=%b, required cols=%b kv=0", i, cols, key_valid, ec);
            end
        end
    endtask

    task automatic test_press_5();
        bit ok;
        expect_digit(4'h5);
        drive_edge();
        pressed[5] = 1'b1;
        wait_pulse(200, ok);
        n_checks++;
        if (!ok || digit_new !== 4'h5 || digit_old !== 4'h0 || cols !== 4'b1101) begin
            n_fail++;
            $display("FAIL press5_accept: got ok=%0d old=%h new=%h cols=%b, required 1 0 5 1101",
                     ok, digit_old, digit_new, cols);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n_checks++;
            if (cols !== 4'b1101 || key_valid !== 1'b0 || digit_new !== 4'h5) begin
                n_fail++;
                $display("FAIL press5_hold[%0d]: got cols=%b kv=%b new=%h, required 1101 0 5",
                         i, cols, key_valid, digit_new);
            end
        end
        drive_edge();
        pressed[5] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (cols !== 4'b1101) begin
                n_fail++;
                $display("FAIL press5_release_frozen[%0d]: got cols=%b, required 1101", k, cols);
            end
            if (k == 3) begin
                n_checks++;
                if (state_dbg !== S_RELEASE) begin
                    n_fail++;
                    $display("FAIL press5_release_state: got %0d, required %0d", state_dbg, S_RELEASE);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (cols !== 4'b1011 || state_dbg !== S_SCAN) begin
            n_fail++;
            $display("FAIL press5_release_done: got cols=%b st=%0d, required 1011 0", cols, state_dbg);
        end
    endtask

    task automatic test_two_digits();
        bit ok_a, ok_b;
        press_release(10, 4'h9, ok_a);
        press_release(3, 4'hA, ok_b);
        n_checks++;
        if (!ok_a || !ok_b || digit_old !== 4'h9 || digit_new !== 4'hA) begin
            n_fail++;
            $display("FAIL two_digits: got ok=%0d%0d old=%h new=%h, required 11 9 A",
                     ok_a, ok_b, digit_old, digit_new);
        end
    endtask

    task automatic test_press_bounce();
        bit ok1, ok2, ok3, ok4, ok5;
        int p0;
        p0 = pulse_cnt;
        expect_digit(4'h7);
        drive_edge();
        pressed[8] = 1'b1;
        // Glitch at DEBOUNCE cycle 2.
        wait_state(S_DEBOUNCE, 100, ok1);
        repeat (2) drive_edge();
        pressed[8] = 1'b0;
        drive_edge();
        pressed[8] = 1'b1;
        wait_state(S_SCAN, 20, ok2);
        // Glitch at DEBOUNCE cycle 5; it reaches rs on the last count.
        wait_state(S_DEBOUNCE, 100, ok3);
        repeat (5) drive_edge();
        pressed[8] = 1'b0;
        drive_edge();
        pressed[8] = 1'b1;
        wait_state(S_SCAN, 20, ok4);
        n_checks++;
        if (!(ok1 && ok2 && ok3 && ok4) || pulse_cnt != p0) begin
            n_fail++;
            $display("FAIL bounce_abort: got ok=%0d%0d%0d%0d pulses=%0d, required 1111 %0d",
                     ok1, ok2, ok3, ok4, pulse_cnt, p0);
        end
        wait_state(S_DEBOUNCE, 100, ok5);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_checks++;
            if (key_valid !== ((k == 8) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL bounce_pulse_time[%0d]: got kv=%b ok=%0d, required %0d",
                         k, key_valid, ok5, (k == 8));
            end
        end
        drive_edge();
        pressed[8] = 1'b0;
        wait_state(S_SCAN, 40, ok1);
        @(posedge clk);
        n_checks++;
        if (!ok1 || pulse_cnt != p0 + 1 || digit_new !== 4'h7) begin
            n_fail++;
            $display("FAIL bounce_single: got ok=%0d pulses=%0d new=%h, required 1 %0d 7",
                     ok1, pulse_cnt, digit_new, p0 + 1);
        end
    endtask

    task automatic test_release_bounce();
        bit ok1, ok2, ok3, ok4;
        int p1;
        expect_digit(4'h3);
        drive_edge();
        pressed[2] = 1'b1;
        wait_pulse(200, ok1);
        drive_edge();
        p1 = pulse_cnt;
        pressed[6] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (cols !== 4'b1011 || key_valid !== 1'b0 || state_dbg !== S_HELD) begin
                n_fail++;
                $display("FAIL second_key_held[%0d]: got cols=%b kv=%b st=%0d, required 1011 0 2",
                         i, cols, key_valid, state_dbg);
            end
        end
        drive_edge();
        pressed[2] = 1'b0;
        pressed[6] = 1'b0;
        wait_state(S_RELEASE, 10, ok2);
        repeat (3) drive_edge();
        pressed[2] = 1'b1;
        drive_edge();
        pressed[2] = 1'b0;
        wait_state(S_HELD, 10, ok3);
        n_checks++;
        if (!(ok1 && ok2 && ok3) || cols !== 4'b1011) begin
            n_fail++;
            $display("FAIL release_bounce_held: got ok=%0d%0d%0d cols=%b, required 111 1011",
                     ok1, ok2, ok3, cols);
        end
        wait_state(S_SCAN, 40, ok4);
        @(posedge clk);
        n_checks++;
        if (!ok4 || pulse_cnt != p1 || digit_old !== exp_old || digit_new !== exp_new) begin
            n_fail++;
            $display("FAIL release_bounce_digits: got ok=%0d pulses=%0d old=%h new=%h, required 1 %0d %h %h",
                     ok4, pulse_cnt, digit_old, digit_new, p1, exp_old, exp_new);
        end
    endtask

    task automatic test_two_rows();
        int p0, changes;
        bit bad;
        logic [3:0] prev;
        p0 = pulse_cnt;
        changes = 0;
        bad = 1'b0;
        drive_edge();
        pressed[1] = 1'b1;
        pressed[5] = 1'b1;
        @(negedge clk);
        prev = cols;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (cols !== prev) changes++;
            prev = cols;
            if (state_dbg !== S_SCAN) bad = 1'b1;
        end
        n_checks++;
        if (bad || changes < 11) begin
            n_fail++;
            $display("FAIL two_rows_scan: got left_scan=%0d col_changes=%0d, required 0 >=11", bad, changes);
        end
        drive_edge();
        pressed = 16'h0;
        repeat (8) @(posedge clk);
        n_checks++;
        if (pulse_cnt != p0) begin
            n_fail++;
            $display("FAIL two_rows_pulse: got %0d pulses, required %0d", pulse_cnt, p0);
        end
    endtask

    task automatic test_reset_mid_debounce();
        bit ok;
        int p0;
        p0 = pulse_cnt;
        drive_edge();
        pressed[13] = 1'b1;
        wait_state(S_DEBOUNCE, 100, ok);
        repeat (3) drive_edge();
        reset = 1'b1;
        pressed = 16'h0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (!ok || cols !== 4'b1110 || digit_old !== 4'h0 || digit_new !== 4'h0 ||
            key_valid !== 1'b0 || state_dbg !== S_SCAN) begin
            n_fail++;
            $display("FAIL mid_reset_values: got ok=%0d cols=%b old=%h new=%h kv=%b st=%0d, required 1 1110 0 0 0 0",
                     ok, cols, digit_old, digit_new, key_valid, state_dbg);
        end
        exp_old = 4'h0;
        exp_new = 4'h0;
        drive_edge();
        reset = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (pulse_cnt != p0 || digit_old !== 4'h0 || digit_new !== 4'h0) begin
            n_fail++;
            $display("FAIL mid_reset_no_pulse: got pulses=%0d old=%h new=%h, required %0d 0 0",
                     pulse_cnt, digit_old, digit_new, p0);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_press_5();
        test_two_digits();
        test_press_bounce();
        test_release_bounce();
        test_two_rows();
        test_reset_mid_debounce();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_expected: got %0d unmatched entries, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
